// File: rtl/sn74169_pkg.sv
// Shared types and constants for the sn74169 control sequencer.
package sn74169_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RELOAD
    } state_t;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_RELOAD = 1'b1;

    localparam logic [3:0] TERM_UP = 4'hF;
    localparam logic [3:0] TERM_DN = 4'h0;

    function automatic logic [3:0] term_of(input logic dir);
        return dir ? TERM_UP : TERM_DN;
    endfunction

endpackage

// File: rtl/sn74169_seq.sv
// Command-driven sequencer for an sn74169 up/down counter: loads,
// enables and reloads the counter and reports terminal-count ticks.
module sn74169_seq
    import sn74169_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic [3:0]    CMD_PRESET,
    input  logic          CMD_DIR,
    input  logic          CMD_MODE,
    input  logic [PW-1:0] CMD_PERIODS,
    input  logic          PAUSE,
    input  logic          ABORT,
    input  logic [3:0]    CNT_Q,
    output logic [3:0]    CNT_A,
    output logic          CNT_U_DB,
    output logic          CNT_ENPB,
    output logic          CNT_ENTB,
    output logic          CNT_LOADB,
    output logic          BUSY,
    output logic          TC_PULSE,
    output logic          DONE,
    output logic          ABORTED,
    output logic [PW-1:0] REMAIN
);

    state_t state;
    logic   mode_r;
    logic   cnt_en;
    logic   tc_evt;

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);

    // The counter only advances when our own registered pins enable it,
    // so terminal count is judged from those pins and the live Q.
    assign cnt_en = !CNT_ENPB && !CNT_ENTB && CNT_LOADB;
    assign tc_evt = cnt_en && (CNT_Q == term_of(CNT_U_DB));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            mode_r    <= MODE_WRAP;
            CNT_A     <= 4'h0;
            CNT_U_DB  <= 1'b1;
            CNT_ENPB  <= 1'b1;
            CNT_ENTB  <= 1'b1;
            CNT_LOADB <= 1'b1;
            TC_PULSE  <= 1'b0;
            DONE      <= 1'b0;
            ABORTED   <= 1'b0;
            REMAIN    <= '0;
        end else begin
            TC_PULSE <= 1'b0;
            DONE     <= 1'b0;
            ABORTED  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        mode_r    <= CMD_MODE;
                        REMAIN    <= CMD_PERIODS;
                        CNT_A     <= CMD_PRESET;
                        CNT_U_DB  <= CMD_DIR;
                        CNT_LOADB <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD, RELOAD: begin
                    if (ABORT) begin
                        CNT_ENPB  <= 1'b1;
                        CNT_ENTB  <= 1'b1;
                        CNT_LOADB <= 1'b1;
                        ABORTED   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        CNT_LOADB <= 1'b1;
                        CNT_ENPB  <= PAUSE;
                        CNT_ENTB  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (ABORT) begin
                        CNT_ENPB  <= 1'b1;
                        CNT_ENTB  <= 1'b1;
                        CNT_LOADB <= 1'b1;
                        ABORTED   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        CNT_ENPB <= PAUSE;
                        if (tc_evt) begin
                            TC_PULSE <= 1'b1;
                            if (REMAIN != '0)
                                REMAIN <= REMAIN - PW'(1);
                            if (REMAIN == PW'(1)) begin
                                CNT_ENPB <= 1'b1;
                                CNT_ENTB <= 1'b1;
                                DONE     <= 1'b1;
                                state    <= IDLE;
                            end else if (mode_r == MODE_RELOAD) begin
                                CNT_ENPB  <= 1'b1;
                                CNT_ENTB  <= 1'b1;
                                CNT_LOADB <= 1'b0;
                                state     <= RELOAD;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sn74169_seq.sv
// Bench for sn74169_seq with a behavioural sn74169 counter wired to it.
module tb_sn74169_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [3:0] CMD_PRESET = 4'h0;
    logic       CMD_DIR = 1'b0;
    logic       CMD_MODE = 1'b0;
    logic [7:0] CMD_PERIODS = 8'h0;
    logic       PAUSE = 1'b0;
    logic       ABORT = 1'b0;
    logic [3:0] CNT_Q = 4'h0;
    logic [3:0] CNT_A;
    logic       CNT_U_DB;
    logic       CNT_ENPB;
    logic       CNT_ENTB;
    logic       CNT_LOADB;
    logic       BUSY;
    logic       TC_PULSE;
    logic       DONE;
    logic       ABORTED;
    logic [7:0] REMAIN;

    sn74169_seq #(.PW(8)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_PRESET(CMD_PRESET), .CMD_DIR(CMD_DIR),
        .CMD_MODE(CMD_MODE), .CMD_PERIODS(CMD_PERIODS),
        .PAUSE(PAUSE), .ABORT(ABORT), .CNT_Q(CNT_Q),
        .CNT_A(CNT_A), .CNT_U_DB(CNT_U_DB),
        .CNT_ENPB(CNT_ENPB), .CNT_ENTB(CNT_ENTB),
        .CNT_LOADB(CNT_LOADB), .BUSY(BUSY),
        .TC_PULSE(TC_PULSE), .DONE(DONE),
        .ABORTED(ABORTED), .REMAIN(REMAIN)
    );

    always #5 CLK = ~CLK;

    // sn74169: sync load, count when both enables low, frozen under RST
    always @(posedge CLK) begin
        if (!RST) begin
            if (!CNT_LOADB)
                CNT_Q <= CNT_A;
            else if (!CNT_ENPB && !CNT_ENTB)
                CNT_Q <= CNT_U_DB ? CNT_Q + 4'd1 : CNT_Q - 4'd1;
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         tc;
        bit         dn;
        bit         ab;
        logic [3:0] q;
        logic [7:0] rem;
        logic [2:0] pins;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  c0 = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic expect_ev(input int c, input bit tc, input bit dn,
                             input bit ab, input logic [3:0] q,
                             input logic [7:0] rem, input logic [2:0] pins);
        ev_t e;
        e.at = c0 + c; e.tc = tc; e.dn = dn; e.ab = ab;
        e.q = q; e.rem = rem; e.pins = pins;
        sb.push_back(e);
    endtask

    task automatic at_cycle(input int n);
        @(negedge CLK);
        while (cyc < c0 + n) @(negedge CLK);
    endtask

    task automatic issue(input logic [3:0] p, input logic d, input logic m,
                         input logic [7:0] n);
        int w;
        w = 0;
        @(negedge CLK);
        while (!CMD_READY && w < 100) begin
            @(negedge CLK);
            w++;
        end
        chk("ready_before_issue", 32'(CMD_READY), 32'd1);
        CMD_PRESET = p; CMD_DIR = d; CMD_MODE = m; CMD_PERIODS = n;
        CMD_VALID = 1'b1;
        c0 = cyc;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
    endtask

    // Monitor: every reported tick/completion is matched against the queue
    always @(negedge CLK) begin
        ev_t e;
        if (!RST && (TC_PULSE || DONE || ABORTED)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: cyc=%0d tc=%b done=%b ab=%b",
                         cyc - c0, TC_PULSE, DONE, ABORTED);
            end else begin
                e = sb.pop_front();
                if (cyc != e.at || TC_PULSE !== e.tc || DONE !== e.dn ||
                    ABORTED !== e.ab || CNT_Q !== e.q || REMAIN !== e.rem ||
                    {CNT_LOADB, CNT_ENPB, CNT_ENTB} !== e.pins) begin
                    n_err++;
                    $display("FAIL event: got cyc=%0d tc=%b dn=%b ab=%b q=%0d rem=%0d pins=%b, expected cyc=%0d tc=%b dn=%b ab=%b q=%0d rem=%0d pins=%b",
                             cyc - c0, TC_PULSE, DONE, ABORTED, CNT_Q,
                             REMAIN, {CNT_LOADB, CNT_ENPB, CNT_ENTB},
                             e.at - c0, e.tc, e.dn, e.ab, e.q, e.rem,
                             e.pins);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 RST = 1'b1;
        @(negedge CLK);
        chk("rst_ready", 32'(CMD_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_pins", 32'({CNT_LOADB, CNT_ENPB, CNT_ENTB}), 32'h7);
        chk("rst_udb", 32'(CNT_U_DB), 32'd1);
        chk("rst_a", 32'(CNT_A), 32'd0);
        chk("rst_remain", 32'(REMAIN), 32'd0);
        chk("rst_pulses", 32'({TC_PULSE, DONE, ABORTED}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // mode0 up, preset 12, one period
        issue(4'd12, 1'b1, 1'b0, 8'd1);
        expect_ev(6, 1, 1, 0, 4'd0, 8'd0, 3'b111);
        at_cycle(1);
        chk("t1_loadb", 32'(CNT_LOADB), 32'd0);
        for (int n = 2; n <= 5; n++) begin
            at_cycle(n);
            chk("t1_q", 32'(CNT_Q), 32'(10 + n));
        end
        at_cycle(6);
        chk("t1_ready", 32'(CMD_READY), 32'd1);

        // mode1 down, preset 2, three periods
        issue(4'd2, 1'b0, 1'b1, 8'd3);
        expect_ev(5, 1, 0, 0, 4'd15, 8'd2, 3'b011);
        expect_ev(9, 1, 0, 0, 4'd15, 8'd1, 3'b011);
        expect_ev(13, 1, 1, 0, 4'd15, 8'd0, 3'b111);
        at_cycle(6);
        chk("t2_reload1", 32'(CNT_Q), 32'd2);
        at_cycle(10);
        chk("t2_reload2", 32'(CNT_Q), 32'd2);
        at_cycle(14);
        chk("t2_ready", 32'(CMD_READY), 32'd1);

        // pause for three cycles delays completion by three
        issue(4'd12, 1'b1, 1'b0, 8'd1);
        expect_ev(9, 1, 1, 0, 4'd0, 8'd0, 3'b111);
        at_cycle(3);
        PAUSE = 1'b1;
        at_cycle(4);
        chk("t3_q_c4", 32'(CNT_Q), 32'd14);
        at_cycle(6);
        PAUSE = 1'b0;
        chk("t3_q_c6", 32'(CNT_Q), 32'd14);
        at_cycle(10);
        chk("t3_ready", 32'(CMD_READY), 32'd1);

        // abort coincident with final terminal count
        issue(4'd12, 1'b1, 1'b0, 8'd1);
        expect_ev(6, 0, 0, 1, 4'd0, 8'd1, 3'b111);
        at_cycle(5);
        chk("t4_q15", 32'(CNT_Q), 32'd15);
        ABORT = 1'b1;
        at_cycle(6);
        ABORT = 1'b0;
        at_cycle(7);
        chk("t4_ready", 32'(CMD_READY), 32'd1);

        // free-run: five periods of 16, then abort
        issue(4'd0, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 5; k++)
            expect_ev(18 + 16 * k, 1, 0, 0, 4'd0, 8'd0, 3'b100);
        expect_ev(86, 0, 0, 1, 4'd4, 8'd0, 3'b111);
        at_cycle(85);
        ABORT = 1'b1;
        at_cycle(86);
        ABORT = 1'b0;
        at_cycle(87);
        chk("t5_ready", 32'(CMD_READY), 32'd1);
        chk("t5_busy", 32'(BUSY), 32'd0);

        // asynchronous reset mid-run freezes the counter
        issue(4'd3, 1'b1, 1'b0, 8'd0);
        at_cycle(10);
        chk("t6_q_before", 32'(CNT_Q), 32'd11);
        RST = 1'b1;
        #1;
        chk("t6_ready", 32'(CMD_READY), 32'd1);
        chk("t6_busy", 32'(BUSY), 32'd0);
        chk("t6_pins", 32'({CNT_LOADB, CNT_ENPB, CNT_ENTB}), 32'h7);
        chk("t6_remain", 32'(REMAIN), 32'd0);
        repeat (2) @(negedge CLK);
        chk("t6_q_held", 32'(CNT_Q), 32'd11);
        RST = 1'b0;

        repeat (3) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sn74169_seq.md
Name: sn74169_seq

Overview:
- Upstream control sequencer for the sn74169 4-bit up/down counter.
- Accepts a timing command over a valid/ready handshake: preset, direction, mode, period count.
- Drives the counter's A/U_DB/ENPB/ENTB/LOADB pins and watches its Q output to detect terminal count.
- Reports per-period ticks and completion to the system.

Parameters:
PW, 8, width of the period-count field and the remaining-period counter

Ports:
CLK  input  1  rising-edge clock, shared with the sn74169
RST  input  1  asynchronous, active-high reset
CMD_VALID  input  1  command offered
CMD_READY  output  1  high exactly when state==IDLE
CMD_PRESET  input  4  value loaded into counter
CMD_DIR  input  1  1=count up, 0=count down
CMD_MODE  input  1  0=wrap (natural counter wrap), 1=reload preset each period
CMD_PERIODS  input  PW  number of terminal counts before done; 0=free-run until ABORT
PAUSE  input  1  hold count while high (RUN only)
ABORT  input  1  stop current command
CNT_Q  input  4  counter Q
CNT_A  output  4  to counter A
CNT_U_DB  output  1  to counter U_DB
CNT_ENPB  output  1  to counter ENPB, active-low
CNT_ENTB  output  1  to counter ENTB, active-low
CNT_LOADB  output  1  to counter LOADB, active-low
BUSY  output  1  state!=IDLE
TC_PULSE  output  1  one-cycle tick per terminal count
DONE  output  1  one-cycle pulse, command completed normally
ABORTED  output  1  one-cycle pulse, command aborted
REMAIN  output  PW  remaining periods

Behaviour:
- Reset (async):
  - State IDLE.
  - CNT_LOADB=CNT_ENPB=CNT_ENTB=1, CNT_U_DB=1, CNT_A=0.
  - TC_PULSE=DONE=ABORTED=0, REMAIN=0.
  - The counter freezes while RST is high; its Q is not cleared.
- All counter-pin outputs, TC_PULSE, DONE, ABORTED and REMAIN are registered. CMD_READY and BUSY decode from state.
- Count-enable term: cnt_en = !CNT_ENPB & !CNT_ENTB & CNT_LOADB, taken from this block's own registered outputs.
- Terminal value: term = 15 if dir=1, 0 if dir=0.
- States:
  - IDLE:
    - On CMD_VALID&CMD_READY, latch preset/dir/mode/periods. REMAIN<=CMD_PERIODS.
    - Set CNT_A<=preset, CNT_U_DB<=dir, CNT_LOADB<=0, then go to LOAD.
    - ABORT and PAUSE are ignored in IDLE.
  - LOAD (1 cycle): the counter loads at this edge.
    - CNT_LOADB<=1.
    - ENPB<=PAUSE, ENTB<=0.
    - Go to RUN.
  - RUN:
    - Each cycle, ENPB<=PAUSE.
    - TC event = cnt_en & CNT_Q==term. The counter wraps at that same edge.
    - On a TC event: TC_PULSE<=1. If REMAIN!=0, REMAIN<=REMAIN-1.
    - Final TC (REMAIN==1): enables<=1, DONE<=1, go to IDLE. The counter ends at the wrapped value (0 up, 15 down).
    - Non-final TC, mode 0: stay in RUN.
    - Non-final TC, mode 1: enables<=1, LOADB<=0, go to RELOAD.
  - RELOAD (1 cycle): the counter reloads the preset.
    - LOADB<=1, ENPB<=PAUSE, ENTB<=0.
    - Go to RUN.
- Period timing:
  - Mode 0: first period is |term-preset|+1 enabled cycles; subsequent periods are 16.
  - Mode 1: every period is |term-preset|+1 enabled cycles plus 1 reload cycle.
  - Preset==term gives a TC in the first enabled cycle.
- ABORT in LOAD/RUN/RELOAD:
  - Next edge: enables<=1, LOADB<=1, ABORTED<=1, go to IDLE.
  - ABORT beats a coincident TC: no TC_PULSE, no DONE, REMAIN unchanged.
- PAUSE:
  - Sampled in RUN/LOAD/RELOAD. One cycle of latency to ENPB.
  - Paused cycles produce no TC and do not advance Q.
- Periods=0: REMAIN stays 0, TC_PULSE every period, never DONE.

Decomposition:
- Shared package sn74169_pkg: state encoding (IDLE, LOAD, RUN, RELOAD), mode constants MODE_WRAP=0 and MODE_RELOAD=1, terminal constants TERM_UP=4'hF and TERM_DN=4'h0.
- No sub-module. The bench instantiates sn74169 alongside this block.

Test Plan:
- Reset: RST=1 mid-RUN -> immediately CMD_READY=1, LOADB/ENPB/ENTB=1, BUSY=0, REMAIN=0; CNT_Q holds its value.
- Mode0 up, preset 12, periods 1, accepted cycle 0:
  - LOADB=0 in cycle 1.
  - Q=12,13,14,15 in cycles 2-5.
  - Cycle 6: TC_PULSE=DONE=1, Q=0, CMD_READY=1.
- Mode1 down, preset 2, periods 3:
  - TC_PULSE at cycles 5, 9, 13.
  - Q reloads to 2 after each non-final TC.
  - DONE at cycle 13, final Q=15.
- PAUSE high for cycles 3-5 on the mode0 up/preset 12 run -> Q holds during the pause; DONE delayed by exactly 3 cycles, at cycle 9.
- ABORT asserted in the cycle where Q=15 on the final period -> next cycle ABORTED=1, DONE=0, TC_PULSE=0, enables=1.
- Periods=0, mode0 up, preset 0 -> TC_PULSE every 16 cycles for 5 periods, REMAIN=0 throughout; then ABORT -> ABORTED pulse, IDLE.
